// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control block.
//   state_e   : run/pause/reset FSM encoding (2 bits)
//   CS_MAX, SEC_MAX, MIN_MAX : last BCD value of each count stage
//   calc_div  : prescaler division ratio from clock and tick rates
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    localparam logic [7:0] CS_MAX  = 8'h99;
    localparam logic [7:0] SEC_MAX = 8'h59;
    localparam logic [7:0] MIN_MAX = 8'h59;

    // Clock cycles per centisecond tick; callers must keep the result >= 2.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit packed-BCD modulo counter, 00..MAX_BCD.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear, dominates inc
//   inc      : advance by one
//   q        : count {tens, ones}
//   co       : combinational carry, inc while q == MAX_BCD
module bcd_mod_counter
    import stopwatch_pkg::*;
#(
    parameter logic [7:0] MAX_BCD = CS_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] q,
    output logic       co
);

    logic [7:0] r_q;
    logic [7:0] w_q_inc;

    always_comb begin
        w_q_inc = r_q;
        if (r_q == MAX_BCD) begin
            w_q_inc = 8'h00;
        end else if (r_q[3:0] == 4'h9) begin
            w_q_inc = {r_q[7:4] + 4'h1, 4'h0};
        end else begin
            w_q_inc = {r_q[7:4], r_q[3:0] + 4'h1};
        end
    end

    // Only written on clr/inc so the count holds untouched between ticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= 8'h00;
        end else if (clr) begin
            r_q <= 8'h00;
        end else if (inc) begin
            r_q <= w_q_inc;
        end
    end

    assign q  = r_q;
    assign co = inc && (r_q == MAX_BCD);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: run/pause/clear FSM, centisecond prescaler and mm:ss.cc
// packed-BCD count chain.
//   clk, rst   : system clock (1 kHz nominal), asynchronous active-high reset
//   key_rst_en : one-cycle clear request (wins over everything else)
//   key_ps_en  : one-cycle start/pause toggle
//   running    : registered, high while in RUN
//   cs_bcd, sec_bcd, min_bcd : registered BCD count
//   wrap       : one-cycle pulse after 59:59.99 rolls to 00:00.00
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 1000,
    parameter int unsigned TICK_HZ = 100,
    parameter int unsigned DIV_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_rst_en,
    input  logic       key_ps_en,
    output logic       running,
    output logic [7:0] cs_bcd,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic       wrap
);

    localparam int unsigned     DIV        = calc_div(CLK_HZ, TICK_HZ);
    localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(DIV - 1);

    state_e           r_state;
    state_e           w_state_d;
    logic [DIV_W-1:0] r_presc;
    logic [DIV_W-1:0] w_presc_d;
    logic             r_running;
    logic             r_wrap;
    logic             w_tick;
    logic             w_cs_co;
    logic             w_sec_co;
    logic             w_min_co;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_presc   <= '0;
            r_running <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_presc   <= w_presc_d;
            r_running <= (w_state_d == RUN);
            r_wrap    <= w_min_co;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_presc_d = r_presc;
        w_tick    = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_presc_d = '0;
                if (key_ps_en) begin
                    w_state_d = RUN;
                end
            end
            RUN: begin
                // A pause in the tick cycle still applies the tick first.
                if (r_presc == PRESC_LAST) begin
                    w_presc_d = '0;
                    w_tick    = 1'b1;
                end else begin
                    w_presc_d = r_presc + DIV_W'(1);
                end
                if (key_ps_en) begin
                    w_state_d = PAUSE;
                end
            end
            PAUSE: begin
                // Prescaler frozen so resuming loses no phase.
                if (key_ps_en) begin
                    w_state_d = RUN;
                end
            end
            default: begin
                w_state_d = IDLE;
                w_presc_d = '0;
            end
        endcase
        // Clear dominates start/pause and discards a coincident tick.
        if (key_rst_en) begin
            w_state_d = IDLE;
            w_presc_d = '0;
            w_tick    = 1'b0;
        end
    end

    bcd_mod_counter #(
        .MAX_BCD(CS_MAX)
    ) u_cs (
        .clk(clk),
        .rst(rst),
        .clr(key_rst_en),
        .inc(w_tick),
        .q  (cs_bcd),
        .co (w_cs_co)
    );

    bcd_mod_counter #(
        .MAX_BCD(SEC_MAX)
    ) u_sec (
        .clk(clk),
        .rst(rst),
        .clr(key_rst_en),
        .inc(w_cs_co),
        .q  (sec_bcd),
        .co (w_sec_co)
    );

    bcd_mod_counter #(
        .MAX_BCD(MIN_MAX)
    ) u_min (
        .clk(clk),
        .rst(rst),
        .clr(key_rst_en),
        .inc(w_sec_co),
        .q  (min_bcd),
        .co (w_min_co)
    );

    assign running = r_running;
    assign wrap    = r_wrap;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: stimulus pushes expected outputs tagged
// with the clock edge they belong to (or "now" for off-edge checks); a monitor
// pops and compares them on the falling edge or on demand.
module tb_stopwatch_ctrl;

    logic       clk;
    logic       rst;
    logic       key_rst_en;
    logic       key_ps_en;
    logic       running;
    logic [7:0] cs_bcd;
    logic [7:0] sec_bcd;
    logic [7:0] min_bcd;
    logic       wrap;

    stopwatch_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .key_rst_en(key_rst_en),
        .key_ps_en (key_ps_en),
        .running   (running),
        .cs_bcd    (cs_bcd),
        .sec_bcd   (sec_bcd),
        .min_bcd   (min_bcd),
        .wrap      (wrap)
    );

    typedef struct {
        int         cyc;
        bit         now;
        string      name;
        logic       run;
        logic [7:0] mn;
        logic [7:0] sc;
        logic [7:0] cs;
        logic       wr;
    } exp_t;

    exp_t q_exp[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    event sample_now;

    initial begin
        clk = 1'b0;
        forever #500 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every due expectation against the live outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or sample_now);
            while (q_exp.size() > 0 && (q_exp[0].now || q_exp[0].cyc <= cyc)) begin
                e = q_exp.pop_front();
                checks++;
                if (running !== e.run || min_bcd !== e.mn || sec_bcd !== e.sc ||
                    cs_bcd !== e.cs || wrap !== e.wr) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got run=%b %h:%h.%h wrap=%b want run=%b %h:%h.%h wrap=%b",
                             e.name, cyc, running, min_bcd, sec_bcd, cs_bcd, wrap,
                             e.run, e.mn, e.sc, e.cs, e.wr);
                end
            end
        end
    end

    task automatic exp_at(input int c, input string nm, input logic run, input logic [7:0] mn,
                          input logic [7:0] sc, input logic [7:0] cs, input logic wr);
        exp_t e;
        e.cyc = c; e.now = 1'b0; e.name = nm;
        e.run = run; e.mn = mn; e.sc = sc; e.cs = cs; e.wr = wr;
        q_exp.push_back(e);
    endtask

    task automatic exp_now(input string nm, input logic run, input logic [7:0] mn,
                           input logic [7:0] sc, input logic [7:0] cs, input logic wr);
        exp_t e;
        e.cyc = cyc; e.now = 1'b1; e.name = nm;
        e.run = run; e.mn = mn; e.sc = sc; e.cs = cs; e.wr = wr;
        q_exp.push_back(e);
        -> sample_now;
        #1;
    endtask

    // All stimulus resumes 1 time unit after a rising edge.
    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive the keys for one cycle; e returns the edge that sampled them.
    task automatic pulse(input logic ps, input logic rs, output int e);
        key_ps_en  = ps;
        key_rst_en = rs;
        @(posedge clk);
        #1;
        key_ps_en  = 1'b0;
        key_rst_en = 1'b0;
        e = cyc;
    endtask

    initial begin
        int b, e0, e1, e2, p, r, p2, r2, e3;
        rst        = 1'b1;
        key_rst_en = 1'b0;
        key_ps_en  = 1'b0;

        // Reset and idle.
        repeat (2) @(posedge clk);
        #1;
        exp_now("reset_hold", 0, 8'h00, 8'h00, 8'h00, 0);
        rst = 1'b0;
        b = cyc;
        for (int i = 1; i <= 50; i++) exp_at(b + i, "idle", 0, 8'h00, 8'h00, 8'h00, 0);
        wait_until(b + 50);

        // Start and first ticks.
        pulse(1, 0, e0);
        exp_at(e0,        "run_start",  1, 8'h00, 8'h00, 8'h00, 0);
        exp_at(e0 + 9,    "pre_tick",   1, 8'h00, 8'h00, 8'h00, 0);
        exp_at(e0 + 10,   "first_tick", 1, 8'h00, 8'h00, 8'h01, 0);
        exp_at(e0 + 99,   "cs_09",      1, 8'h00, 8'h00, 8'h09, 0);
        exp_at(e0 + 100,  "cs_10",      1, 8'h00, 8'h00, 8'h10, 0);
        exp_at(e0 + 999,  "cs_99",      1, 8'h00, 8'h00, 8'h99, 0);
        exp_at(e0 + 1000, "sec_carry",  1, 8'h00, 8'h01, 8'h00, 0);
        exp_at(e0 + 1479, "pre_clear",  1, 8'h00, 8'h01, 8'h47, 0);
        wait_until(e0 + 1479);

        // Clear + toggle together, coinciding with a tick: clear wins.
        pulse(1, 1, e1);
        exp_at(e1,     "clear",      0, 8'h00, 8'h00, 8'h00, 0);
        exp_at(e1 + 5, "clear_hold", 0, 8'h00, 8'h00, 8'h00, 0);
        wait_until(e1 + 5);

        // Restart, then pause mid-period and resume without phase loss.
        pulse(1, 0, e2);
        exp_at(e2,      "restart",      1, 8'h00, 8'h00, 8'h00, 0);
        exp_at(e2 + 9,  "restart_pre",  1, 8'h00, 8'h00, 8'h00, 0);
        exp_at(e2 + 10, "restart_tick", 1, 8'h00, 8'h00, 8'h01, 0);
        exp_at(e2 + 24, "pre_pause",    1, 8'h00, 8'h00, 8'h02, 0);
        wait_until(e2 + 24);
        pulse(1, 0, p);
        exp_at(p,       "pause",        0, 8'h00, 8'h00, 8'h02, 0);
        exp_at(p + 100, "pause_frozen", 0, 8'h00, 8'h00, 8'h02, 0);
        wait_until(p + 100);
        pulse(1, 0, r);
        exp_at(r,      "resume",       1, 8'h00, 8'h00, 8'h02, 0);
        exp_at(r + 4,  "resume_pre",   1, 8'h00, 8'h00, 8'h02, 0);
        exp_at(r + 5,  "resume_phase", 1, 8'h00, 8'h00, 8'h03, 0);
        exp_at(r + 14, "pre_tick_ps",  1, 8'h00, 8'h00, 8'h03, 0);
        wait_until(r + 14);

        // Pause in the tick cycle: tick applied, then frozen.
        pulse(1, 0, p2);
        exp_at(p2,     "pause_on_tick", 0, 8'h00, 8'h00, 8'h04, 0);
        exp_at(p2 + 3, "pause_on_tick_hold", 0, 8'h00, 8'h00, 8'h04, 0);
        wait_until(p2 + 4);

        // Preload 59:59.99 while paused, then resume into the wrap.
        force dut.u_cs.r_q  = 8'h99;
        force dut.u_sec.r_q = 8'h59;
        force dut.u_min.r_q = 8'h59;
        #1;
        release dut.u_cs.r_q;
        release dut.u_sec.r_q;
        release dut.u_min.r_q;
        exp_now("preload_max", 0, 8'h59, 8'h59, 8'h99, 0);
        pulse(1, 0, r2);
        exp_at(r2,      "wrap_resume", 1, 8'h59, 8'h59, 8'h99, 0);
        exp_at(r2 + 9,  "wrap_pre",    1, 8'h59, 8'h59, 8'h99, 0);
        exp_at(r2 + 10, "wrap_pulse",  1, 8'h00, 8'h00, 8'h00, 1);
        exp_at(r2 + 11, "wrap_drop",   1, 8'h00, 8'h00, 8'h00, 0);
        exp_at(r2 + 20, "wrap_cont",   1, 8'h00, 8'h00, 8'h01, 0);
        wait_until(r2 + 21);

        // Asynchronous reset off-edge while running at 12:34.56.
        force dut.u_cs.r_q  = 8'h56;
        force dut.u_sec.r_q = 8'h34;
        force dut.u_min.r_q = 8'h12;
        #1;
        release dut.u_cs.r_q;
        release dut.u_sec.r_q;
        release dut.u_min.r_q;
        exp_now("preload_mid", 1, 8'h12, 8'h34, 8'h56, 0);
        #200;
        rst = 1'b1;
        #1;
        exp_now("async_rst", 0, 8'h00, 8'h00, 8'h00, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        b = cyc;
        for (int i = 1; i <= 20; i++) exp_at(b + i, "post_rst_idle", 0, 8'h00, 8'h00, 8'h00, 0);
        wait_until(b + 20);
        pulse(1, 0, e3);
        exp_at(e3,      "post_rst_start", 1, 8'h00, 8'h00, 8'h00, 0);
        exp_at(e3 + 10, "post_rst_tick",  1, 8'h00, 8'h00, 8'h01, 0);
        wait_until(e3 + 10);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 5 && q_exp.size() > 0; i++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (q_exp.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", q_exp.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
